// File: rtl/dpram_fifo_ctl.sv
// dpram_fifo_ctl
// Single-clock, non-FWFT FIFO controller that acts as the initiator for an
// external dual-port block RAM (dpram_xlx). Port A of the RAM is the write
// port and port B is the read port. Read data comes straight from the RAM
// output register, so a pop shows up on rd_data one cycle after it is accepted.
// DEPTH need not be a power of two: both pointers wrap at DEPTH-1.
//
// Optional build macro: DPRAM_FIFO_ERR_FLAGS_EN
//   When defined, adds sticky overflow/underflow outputs. They are cleared
//   only by rst.

module dpram_fifo_ctl #(
    parameter int ADDRWIDTH = 4,
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    // push side
    input  logic                 wr_en,
    input  logic [DATAWIDTH-1:0] wr_data,
    output logic                 full,

    // pop side
    input  logic                 rd_en,
    output logic [DATAWIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 empty,
    output logic [ADDRWIDTH:0]   count,

    // RAM port A (write)
    output logic                 ram_ena,
    output logic                 ram_wea,
    output logic [ADDRWIDTH-1:0] ram_addra,
    output logic [DATAWIDTH-1:0] ram_dina,

    // RAM port B (read)
    output logic                 ram_enb,
    output logic                 ram_web,
    output logic [ADDRWIDTH-1:0] ram_addrb,
    output logic [DATAWIDTH-1:0] ram_dinb,
    input  logic [DATAWIDTH-1:0] ram_doutb
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
    ,
    output logic                 overflow,
    output logic                 underflow
`endif
);

    localparam logic [ADDRWIDTH-1:0] PTR_LAST = ADDRWIDTH'(DEPTH - 1);
    localparam logic [ADDRWIDTH-1:0] PTR_ONE  = ADDRWIDTH'(1);
    localparam logic [ADDRWIDTH:0]   CNT_FULL = (ADDRWIDTH + 1)'(DEPTH);
    localparam logic [ADDRWIDTH:0]   CNT_ONE  = (ADDRWIDTH + 1)'(1);

    logic [ADDRWIDTH-1:0] r_wr_ptr;
    logic [ADDRWIDTH-1:0] r_rd_ptr;
    logic [ADDRWIDTH:0]   r_count;
    logic                 r_full;
    logic                 r_empty;
    logic                 r_rd_valid;

    logic                 w_push;
    logic                 w_pop;
    logic [ADDRWIDTH-1:0] w_wr_ptr_next;
    logic [ADDRWIDTH-1:0] w_rd_ptr_next;
    logic [ADDRWIDTH:0]   w_count_next;

    // Accept decisions use the registered flags. Gating with rst keeps both
    // RAM enables low while reset is asserted and stops a pop from being
    // launched in a reset cycle.
    assign w_push = wr_en & ~r_full  & ~rst;
    assign w_pop  = rd_en & ~r_empty & ~rst;

    // Compute the next pointers, wrapping at DEPTH-1 rather than at 2**ADDRWIDTH.
    always_comb begin
        w_wr_ptr_next = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_ONE;
        w_rd_ptr_next = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_ONE;
    end

    // Compute the next occupancy. A simultaneous push and pop cancel out.
    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_ONE;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CNT_ONE;
        end
    end

    // Update pointers, count, flags and read-valid on each clock edge.
    // The flags are derived from the next count so that they change on the same edge as count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            r_count    <= w_count_next;
            r_full     <= (w_count_next == CNT_FULL);
            r_empty    <= (w_count_next == '0);
            r_rd_valid <= w_pop;
        end
    end

`ifdef DPRAM_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Latch any request that hits a blocked side. The flag stays set until rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= r_overflow  | (wr_en & r_full);
            r_underflow <= r_underflow | (rd_en & r_empty);
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

    // Status outputs
    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign rd_valid = r_rd_valid;
    assign rd_data  = ram_doutb;

    // RAM drive. Pops are blocked when empty and pushes are blocked when full,
    // so both ports never address the same location in the same cycle.
    assign ram_ena   = w_push;
    assign ram_wea   = w_push;
    assign ram_addra = r_wr_ptr;
    assign ram_dina  = wr_data;
    assign ram_enb   = w_pop;
    assign ram_web   = 1'b0;
    assign ram_addrb = r_rd_ptr;
    assign ram_dinb  = '0;

endmodule

// File: tb/tb_dpram_fifo_ctl.sv
// Testbench for dpram_fifo_ctl.
// Two instances share one stimulus stream: DEPTH=16 and DEPTH=12. The
// DEPTH=12 instance exercises wrapping at a depth that is not a power of two.
// Each instance drives its own behavioural 1-cycle-latency RAM. The
// reference model tracks the total pushes and pops since reset. Occupancy,
// addresses and data then follow from plain arithmetic.
// Define DPRAM_FIFO_ERR_FLAGS_EN to also check the sticky error flags.

module tb_dpram_fifo_ctl;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] wr_data;

    logic          full_s   [2];
    logic          empty_s  [2];
    logic          valid_s  [2];
    logic [DW-1:0] rdata_s  [2];
    logic [AW:0]   count_s  [2];
    logic          ena_s    [2];
    logic          wea_s    [2];
    logic [AW-1:0] addra_s  [2];
    logic [DW-1:0] dina_s   [2];
    logic          enb_s    [2];
    logic          web_s    [2];
    logic [AW-1:0] addrb_s  [2];
    logic [DW-1:0] dinb_s   [2];
    logic [DW-1:0] doutb_s  [2];
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
    logic          ovf_s    [2];
    logic          unf_s    [2];
`endif

    logic [DW-1:0] ram_mem  [2][16];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int            wn      [2];
    int            rn      [2];
    logic [DW-1:0] store   [2][64];
    bit            valid_m [2];
    logic [DW-1:0] data_m  [2];
    bit            ovf_m   [2];
    bit            unf_m   [2];

    always #5 clk = ~clk;

    dpram_fifo_ctl #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .DEPTH(16)) u_d16 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .full(full_s[0]),
        .rd_en(rd_en), .rd_data(rdata_s[0]), .rd_valid(valid_s[0]),
        .empty(empty_s[0]), .count(count_s[0]),
        .ram_ena(ena_s[0]), .ram_wea(wea_s[0]), .ram_addra(addra_s[0]), .ram_dina(dina_s[0]),
        .ram_enb(enb_s[0]), .ram_web(web_s[0]), .ram_addrb(addrb_s[0]), .ram_dinb(dinb_s[0]),
        .ram_doutb(doutb_s[0])
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
        , .overflow(ovf_s[0]), .underflow(unf_s[0])
`endif
    );

    dpram_fifo_ctl #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .DEPTH(12)) u_d12 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .full(full_s[1]),
        .rd_en(rd_en), .rd_data(rdata_s[1]), .rd_valid(valid_s[1]),
        .empty(empty_s[1]), .count(count_s[1]),
        .ram_ena(ena_s[1]), .ram_wea(wea_s[1]), .ram_addra(addra_s[1]), .ram_dina(dina_s[1]),
        .ram_enb(enb_s[1]), .ram_web(web_s[1]), .ram_addrb(addrb_s[1]), .ram_dinb(dinb_s[1]),
        .ram_doutb(doutb_s[1])
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
        , .overflow(ovf_s[1]), .underflow(unf_s[1])
`endif
    );

    // Behavioural dual-port RAMs with registered read data
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ena_s[i] && wea_s[i]) ram_mem[i][addra_s[i]] <= dina_s[i];
            if (enb_s[i]) doutb_s[i] <= ram_mem[i][addrb_s[i]];
        end
    end

    function automatic int dep(input int i);
        return (i == 0) ? 16 : 12;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus. Check the combinational RAM drive before the
    // edge, then advance the model and check the registered outputs after it.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d, input bit rs);
        bit p [2];
        bit o [2];
        bit fp[2];
        bit ep[2];
        int occ;
        @(negedge clk);
        wr_en = w; rd_en = r; wr_data = d; rst = rs;
        #1;
        for (int i = 0; i < 2; i++) begin
            occ   = wn[i] - rn[i];
            fp[i] = (occ == dep(i));
            ep[i] = (occ == 0);
            p[i]  = w && !rs && !fp[i];
            o[i]  = r && !rs && !ep[i];
            check($sformatf("ram_ena[%0d]", i), 32'(ena_s[i]), 32'(p[i]));
            check($sformatf("ram_wea[%0d]", i), 32'(wea_s[i]), 32'(p[i]));
            check($sformatf("ram_enb[%0d]", i), 32'(enb_s[i]), 32'(o[i]));
            check($sformatf("ram_web[%0d]", i), 32'(web_s[i]), 32'(0));
            check($sformatf("ram_dinb[%0d]", i), 32'(dinb_s[i]), 32'(0));
            if (p[i]) begin
                check($sformatf("ram_addra[%0d]", i), 32'(addra_s[i]), 32'(wn[i] % dep(i)));
                check($sformatf("ram_dina[%0d]", i), 32'(dina_s[i]), 32'(d));
            end
            if (o[i]) check($sformatf("ram_addrb[%0d]", i), 32'(addrb_s[i]), 32'(rn[i] % dep(i)));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rs) begin
                wn[i] = 0; rn[i] = 0; valid_m[i] = 0; ovf_m[i] = 0; unf_m[i] = 0;
            end else begin
                if (w && fp[i]) ovf_m[i] = 1;
                if (r && ep[i]) unf_m[i] = 1;
                valid_m[i] = o[i];
                if (o[i]) begin
                    data_m[i] = store[i][rn[i] % 64];
                    rn[i]++;
                end
                if (p[i]) begin
                    store[i][wn[i] % 64] = d;
                    wn[i]++;
                end
            end
            occ = wn[i] - rn[i];
            check($sformatf("count[%0d]", i), 32'(count_s[i]), 32'(occ));
            check($sformatf("full[%0d]", i), 32'(full_s[i]), 32'(occ == dep(i)));
            check($sformatf("empty[%0d]", i), 32'(empty_s[i]), 32'(occ == 0));
            check($sformatf("rd_valid[%0d]", i), 32'(valid_s[i]), 32'(valid_m[i]));
            if (valid_m[i]) check($sformatf("rd_data[%0d]", i), 32'(rdata_s[i]), 32'(data_m[i]));
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
            check($sformatf("overflow[%0d]", i), 32'(ovf_s[i]), 32'(ovf_m[i]));
            check($sformatf("underflow[%0d]", i), 32'(unf_s[i]), 32'(unf_m[i]));
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        for (int i = 0; i < 2; i++) begin
            wn[i] = 0; rn[i] = 0; valid_m[i] = 0; data_m[i] = '0; ovf_m[i] = 0; unf_m[i] = 0;
        end

        // reset, then idle
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // three pushes, three back-to-back pops
        step(1, 0, 8'h11, 0);
        step(1, 0, 8'h22, 0);
        step(1, 0, 8'h33, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // fill (the DEPTH=12 copy overflows), then hold wr_en while full
        for (int k = 0; k < 16; k++) step(1, 0, 8'(k), 0);
        for (int k = 0; k < 3; k++) step(1, 0, 8'hAA, 0);

        // full with push and pop asserted together: only the pop proceeds
        step(1, 1, 8'hBB, 0);
        step(0, 0, 8'h00, 0);

        // drain past empty
        for (int k = 0; k < 17; k++) step(0, 1, 8'h00, 0);

        // empty with push and pop asserted together: only the push proceeds
        step(1, 1, 8'hC1, 0);
        step(0, 0, 8'h00, 0);

        // fill to half, then push and pop together for 8 cycles
        for (int k = 0; k < 7; k++) step(1, 0, 8'(8'h40 + k), 0);
        for (int k = 0; k < 8; k++) step(1, 1, 8'(8'h50 + k), 0);

        // 30 words at occupancy 5 (wraps 11->0 for DEPTH=12)
        step(0, 0, 8'h00, 1);
        for (int k = 0; k < 5; k++) step(1, 0, 8'(k), 0);
        for (int k = 5; k < 30; k++) step(1, 1, 8'(k), 0);
        for (int k = 0; k < 5; k++) step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // reset while a read is in flight
        step(1, 0, 8'h77, 0);
        step(1, 0, 8'h78, 0);
        step(0, 1, 8'h00, 0);
        step(0, 1, 8'h00, 1);
        step(0, 0, 8'h00, 0);
        step(1, 0, 8'h5A, 0);
        step(0, 1, 8'h00, 0);
        step(0, 0, 8'h00, 0);

        // randomized traffic: a fill-biased phase, then a drain-biased phase
        for (int k = 0; k < 400; k++) begin
            bit w, r, rs;
            if (k < 200) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            rs = ($urandom_range(0, 99) == 0);
            step(w, r, 8'($urandom), rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dpram_fifo_ctl.md
Name: dpram_fifo_ctl

Overview:
Single-clock synchronous FIFO controller. It acts as the initiator for the dual-port block RAM wrapper (dpram_xlx): it drives the RAM's port A as the write port and port B as the read port. It exposes a standard (non-FWFT) push/pop FIFO interface to user logic. The RAM sits outside this block; its clka and clkb are tied to clk at the parent level.

Parameters:
ADDRWIDTH, 4, RAM address width; must match the RAM instance.
DATAWIDTH, 8, data word width; must match the RAM instance.
DEPTH, 16, number of usable entries; 2 <= DEPTH <= 2**ADDRWIDTH; need not be a power of two.

Ports:
clk  input  1  single clock; RAM clka/clkb are tied to this at the parent.
rst  input  1  synchronous reset, active-high.
wr_en  input  1  push request.
wr_data  input  DATAWIDTH  push data.
full  output  1  high when count == DEPTH.
rd_en  input  1  pop request.
rd_data  output  DATAWIDTH  pop data; wired directly from ram_doutb.
rd_valid  output  1  one-cycle pulse; rd_data is valid in that cycle.
empty  output  1  high when count == 0.
count  output  ADDRWIDTH+1  current occupancy.
ram_ena  output  1  drives RAM ena.
ram_wea  output  1  drives RAM wea.
ram_addra  output  ADDRWIDTH  drives RAM addra; equals wr_ptr.
ram_dina  output  DATAWIDTH  drives RAM dina; equals wr_data.
ram_enb  output  1  drives RAM enb.
ram_web  output  1  drives RAM web; constant 0.
ram_addrb  output  ADDRWIDTH  drives RAM addrb; equals rd_ptr.
ram_dinb  output  DATAWIDTH  drives RAM dinb; constant 0.
ram_doutb  input  DATAWIDTH  RAM port B read data, one-cycle latency.

Behaviour:
- Write accept: push = wr_en & ~full. Read accept: pop = rd_en & ~empty. Both are evaluated on the registered flags of the current cycle.
- RAM drive is combinational from the current state:
  - ram_ena = ram_wea = push; ram_addra = wr_ptr.
  - ram_enb = pop; ram_addrb = rd_ptr.
- Pointers:
  - wr_ptr and rd_ptr are ADDRWIDTH-bit registers.
  - On its accept, each pointer increments and wraps DEPTH-1 -> 0. It does not wrap at 2**ADDRWIDTH when DEPTH is smaller.
- count register:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
- full and empty are registered and updated with count in the same edge:
  - full = (next count == DEPTH); empty = (next count == 0).
- Read latency:
  - pop accepted at edge N -> RAM registers data at edge N.
  - rd_valid is a register set to pop, so rd_valid = 1 and rd_data holds the popped word in cycle N+1.
  - Back-to-back pops produce one word per cycle.
- Simultaneous push and pop:
  - Full: push is rejected; pop proceeds; full drops next cycle.
  - Empty: pop is rejected; push proceeds.
  - Otherwise both proceed and count is unchanged.
  - Because pops are blocked when empty and pushes when full, port A and port B never address the same location in the same cycle. No RAM collision handling is needed.
- Rejected requests leave all state unchanged and issue no RAM enable.
- Reset, including mid-operation:
  - wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, full = 0, rd_valid = 0.
  - RAM contents are not cleared.
  - A read in flight when rst asserts has its rd_valid suppressed.
  - ram_ena/ram_enb are 0 during rst.

Optional Feature:
- Macro: DPRAM_FIFO_ERR_FLAGS_EN.
- When defined, the block adds outputs overflow (1 bit) and underflow (1 bit):
  - overflow is sticky, set on wr_en & full.
  - underflow is sticky, set on rd_en & empty.
  - Both are cleared only by rst; reset value is 0.
  - They update in the cycle after the offending request.
- When not defined, these ports and their registers do not exist. Rejected requests are silently dropped.

Test Plan:
- Reset then idle: after rst, empty=1, full=0, count=0, rd_valid=0, ram_ena=ram_enb=0.
- Push 0x11, 0x22, 0x33, then pop 3 times back-to-back -> rd_valid high on the 3 cycles after each pop, rd_data 0x11, 0x22, 0x33; empty=1 afterwards.
- Fill to DEPTH=16 with values 0x00..0x0F -> full=1, count=16. Hold wr_en with 0xAA -> no ram_wea, count stays 16. With DPRAM_FIFO_ERR_FLAGS_EN, overflow=1.
- Non-power-of-two, DEPTH=12, ADDRWIDTH=4: push/pop 30 words 0x00..0x1D with occupancy held at 5 -> data emerges in order; ram_addra never exceeds 11 and wraps 11->0.
- Full and empty simultaneous cases:
  - Full, wr_en=rd_en=1 -> count goes to 15 and only port B is enabled.
  - Empty, both asserted -> count goes to 1 and rd_valid stays 0.
  - Half-full, both asserted for 8 cycles -> count constant.
- Mid-operation reset: assert rst in the cycle after a pop -> rd_valid=0 next cycle, count=0, empty=1. Subsequent push 0x5A / pop returns 0x5A.
